// File: rtl/adder_flit_injector_if.sv
// Flit link between the injector and the downstream adder operands.
// The master drives valid and both operand halves; the slave returns ready.
interface adder_flit_injector_if #(
  parameter int N = 16
);
  logic         valid;
  logic         ready;
  logic [N-1:0] input1;
  logic [N-1:0] input2;

  modport master (output valid, output input1, output input2, input ready);
  modport slave  (input valid, input input1, input input2, output ready);
endinterface

// File: rtl/adder_flit_injector.sv
// Packetized operand injector for the adder with deterministic bit toggling per flit.
// Optional switching-activity counter is enabled by defining ADDER_FLIT_INJECTOR_TOGCNT_EN.
module adder_flit_injector #(
  parameter int N           = 16,
  parameter int PAYLOAD     = 20,
  parameter int GAP_CYCLES  = 7,
  parameter int NUM_PACKETS = 10,
  parameter int TOGGLES     = 8,
  parameter int ROT         = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  adder_flit_injector_if.master  flit,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            pkt_cnt
`ifdef ADDER_FLIT_INJECTOR_TOGCNT_EN
  ,
  output logic [31:0]            toggle_cnt
`endif
);

  localparam int W2    = 2 * N;
  localparam int PW    = (W2 > 1) ? $clog2(W2) : 1;
  localparam int ROT_M = ROT % W2;
  localparam int FW    = $clog2(PAYLOAD) + 1;
  localparam int GW    = $clog2(GAP_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q;
  logic [W2-1:0]   w_q;
  logic [PW-1:0]   p_q;
  logic [FW-1:0]   flit_q;
  logic [GW-1:0]   gap_q;
  logic [15:0]     pkt_q;
  logic            valid_q;
  logic            busy_q;
  logic            done_q;

  logic [W2-1:0]   w_d;
  logic [PW-1:0]   p_d;
  logic [PW:0]     psum;
  logic            pkt_end;
  logic            last_pkt;
  logic            load;

  // TOGGLES consecutive ones starting at bit p, wrapping around the flit word.
  function automatic logic [W2-1:0] mask_f(input logic [PW-1:0] p);
    logic [W2-1:0] m;
    logic [PW:0]   idx;
    m = '0;
    for (int i = 0; i < W2; i++) begin
      idx = {1'b0, p} + (PW+1)'(i);
      if (idx >= (PW+1)'(W2)) idx = idx - (PW+1)'(W2);
      if (i < TOGGLES) m[idx[PW-1:0]] = 1'b1;
    end
    return m;
  endfunction

`ifdef ADDER_FLIT_INJECTOR_TOGCNT_EN
  function automatic logic [31:0] popcnt_f(input logic [W2-1:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < W2; i++) c = c + 32'(v[i]);
    return c;
  endfunction

  logic [31:0] tog_q;
`endif

  always_comb begin
    w_d  = w_q ^ mask_f(p_q);
    psum = {1'b0, p_q} + (PW+1)'(ROT_M);
    if (psum >= (PW+1)'(W2)) psum = psum - (PW+1)'(W2);
    p_d  = psum[PW-1:0];
  end

  // A packet ends on the transfer of its final flit; loads happen on any new flit.
  always_comb begin
    pkt_end  = (state_q == S_SEND) && flit.ready && (flit_q == FW'(PAYLOAD));
    last_pkt = (pkt_q + 16'd1) == 16'(NUM_PACKETS);
    load     = 1'b0;
    case (state_q)
      S_IDLE:  load = start;
      S_SEND:  load = flit.ready &&
                      ((flit_q != FW'(PAYLOAD)) || (!last_pkt && (GAP_CYCLES == 0)));
      S_GAP:   load = (gap_q == GW'(1));
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      p_q     <= '0;
      flit_q  <= '0;
      gap_q   <= '0;
      pkt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ADDER_FLIT_INJECTOR_TOGCNT_EN
      tog_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (load) begin
        w_q     <= w_d;
        p_q     <= p_d;
        valid_q <= 1'b1;
      end
`ifdef ADDER_FLIT_INJECTOR_TOGCNT_EN
      if (state_q == S_IDLE && start) tog_q <= popcnt_f(w_d ^ w_q);
      else if (load)                  tog_q <= tog_q + popcnt_f(w_d ^ w_q);
`endif
      case (state_q)
        S_IDLE: begin
          if (start) begin
            flit_q  <= FW'(1);
            pkt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (pkt_end) begin
            pkt_q <= pkt_q + 16'd1;
            if (last_pkt) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (GAP_CYCLES == 0) begin
              flit_q <= FW'(1);
            end else begin
              valid_q <= 1'b0;
              gap_q   <= GW'(GAP_CYCLES);
              state_q <= S_GAP;
            end
          end else if (flit.ready) begin
            flit_q <= flit_q + FW'(1);
          end
        end
        S_GAP: begin
          if (gap_q == GW'(1)) begin
            flit_q  <= FW'(1);
            state_q <= S_SEND;
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign flit.valid  = valid_q;
  assign flit.input1 = w_q[N-1:0];
  assign flit.input2 = w_q[W2-1:N];
  assign busy        = busy_q;
  assign done        = done_q;
  assign pkt_cnt     = pkt_q;
`ifdef ADDER_FLIT_INJECTOR_TOGCNT_EN
  assign toggle_cnt  = tog_q;
`endif

endmodule
